// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 24;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO feeding the transmitter. DEPTH must be a power of
// two (>= 2) so the pointers wrap on their own. A push on a full FIFO is
// dropped even if a pop happens on the same edge.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage: contents are never reset, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_b && push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first, idle-high line.
//
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (low) for one bit time
//   DATA  | data bits 0..7 from the held shifter byte
//   STOP  | stop bit(s) high; chains straight into START if more data
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [7:0]                  TX_data,
  input  logic                        TX_valid,
  output logic                        TX_ready,
  output logic                        TX,
  output logic                        TX_busy,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_count
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_next;
  logic [7:0]    shifter;
  logic          tx_q;
  logic          baud_end;
  logic          frame_end;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_end && (bit_idx == STOP_LAST);
  assign idx_next  = bit_idx + 3'd1;
  assign pop       = Reset && !empty && ((state == IDLE) || frame_end);

  assign TX_ready  = !full;
  assign TX        = tx_q;
  assign TX_busy   = (state != IDLE) || !empty;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (Clk),
    .rst_b (Reset),
    .push  (TX_valid),
    .din   (TX_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (Fifo_count)
  );

  // Frame sequencer: baud counter, bit index, held shifter byte and line register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!empty) begin
            shifter <= head;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shifter[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              tx_q    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= idx_next;
              tx_q    <= shifter[idx_next];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (!empty) begin
                shifter <= head;
                tx_q    <= 1'b0;
                state   <= START;
              end else begin
                tx_q  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_idx <= idx_next;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, framing, back-to-back, full buffer,
// simultaneous push/pop, mid-frame reset and receiver loopback.
module tb_uart_tx;

  localparam int CPB = 24;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] TX_data = 8'h00;
  logic       TX_valid = 1'b0;
  logic       TX_ready;
  logic       TX;
  logic       TX_busy;
  logic [2:0] Fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .TX_data    (TX_data),
    .TX_valid   (TX_valid),
    .TX_ready   (TX_ready),
    .TX         (TX),
    .TX_busy    (TX_busy),
    .Fifo_count (Fifo_count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bench receiver: mid-bit sampling at 24 clocks per bit.
  task automatic rx_byte(output logic [7:0] data, output bit frame_ok,
                         output bit timed_out, output int start_cyc);
    int waited = 0;
    data = '0; frame_ok = 1'b0; timed_out = 1'b0; start_cyc = 0;
    while (TX !== 1'b0 && waited < 3000) begin
      @(negedge Clk);
      waited++;
    end
    if (TX !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    start_cyc = cyc;
    repeat (CPB/2) @(negedge Clk);
    frame_ok = (TX === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge Clk);
      data[i] = TX;
    end
    repeat (CPB) @(negedge Clk);
    frame_ok = frame_ok && (TX === 1'b1);
  endtask

  task automatic wait_idle(output bit timed_out);
    int k = 0;
    while (TX_busy !== 1'b0 && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    timed_out = (TX_busy !== 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b0; TX_valid = 1'b1; TX_data = 8'hAA;
    repeat (3) @(negedge Clk);
    n_checks++; if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", TX); end
    n_checks++; if (TX_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", TX_busy); end
    n_checks++; if (Fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Fifo_count); end
    n_checks++; if (TX_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", TX_ready); end
    TX_valid = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    n_checks++; if (TX !== 1'b1 || TX_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: got tx=%b busy=%b expected tx=1 busy=0", TX, TX_busy); end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    int errs;
    bit to;
    frame = {1'b1, 8'hA5, 1'b0};
    TX_valid = 1'b1; TX_data = 8'hA5;
    @(negedge Clk);
    TX_valid = 1'b0;
    n_checks++; if (TX !== 1'b1 || Fifo_count !== 3'd1 || TX_busy !== 1'b1) begin n_fail++; $display("FAIL single_accept: got tx=%b count=%0d busy=%b expected tx=1 count=1 busy=1", TX, Fifo_count, TX_busy); end
    @(negedge Clk);
    n_checks++; if (TX !== 1'b0 || Fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_latency: got tx=%b count=%0d expected tx=0 count=0", TX, Fifo_count); end
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int c = 0; c < CPB; c++) begin
        if (TX !== frame[b] || TX_busy !== 1'b1) errs++;
        @(negedge Clk);
      end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL single_bit%0d: got %0d bad samples expected 0 (level %b)", b, errs, frame[b]); end
    end
    n_checks++; if (TX_busy !== 1'b0 || TX !== 1'b1) begin n_fail++; $display("FAIL single_end: got busy=%b tx=%b expected busy=0 tx=1", TX_busy, TX); end
    wait_idle(to);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1;
    bit ok0, ok1, to0, to1, to;
    int s0, s1;
    fork
      begin
        TX_valid = 1'b1; TX_data = 8'h55;
        @(negedge Clk);
        TX_data = 8'h0F;
        @(negedge Clk);
        TX_valid = 1'b0;
      end
      begin
        rx_byte(d0, ok0, to0, s0);
        rx_byte(d1, ok1, to1, s1);
      end
    join
    n_checks++; if (to0 || to1) begin n_fail++; $display("FAIL b2b_timeout: got to0=%b to1=%b expected 0 0", to0, to1); end
    n_checks++; if (d0 !== 8'h55 || d1 !== 8'h0F) begin n_fail++; $display("FAIL b2b_data: got %h %h expected 55 0f", d0, d1); end
    n_checks++; if (!(ok0 && ok1)) begin n_fail++; $display("FAIL b2b_framing: got ok=%b%b expected 11", ok0, ok1); end
    n_checks++; if (s1 - s0 != 10*CPB) begin n_fail++; $display("FAIL b2b_gap: got start spacing %0d expected %0d", s1 - s0, 10*CPB); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", TX_busy); end
  endtask

  task automatic test_full();
    logic [7:0] got [5];
    bit ok [5];
    bit tov [5];
    int st [5];
    int accepted;
    bit to;
    fork
      begin
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
          TX_valid = 1'b1; TX_data = 8'h10 + 8'(i);
          if (TX_ready === 1'b1) accepted++;
          @(negedge Clk);
        end
        TX_valid = 1'b0;
        n_checks++; if (Fifo_count !== 3'd4 || TX_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d ready=%b expected count=4 ready=0", Fifo_count, TX_ready); end
        n_checks++; if (accepted != 5) begin n_fail++; $display("FAIL full_accepted: got %0d expected 5", accepted); end
      end
      begin
        for (int i = 0; i < 5; i++) rx_byte(got[i], ok[i], tov[i], st[i]);
      end
    join
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tov[i] || !ok[i] || got[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_byte%0d: got %h ok=%b to=%b expected %h ok=1 to=0", i, got[i], ok[i], tov[i], 8'h10 + 8'(i)); end
    end
    n_checks++; if (st[4] - st[0] != 40*CPB) begin n_fail++; $display("FAIL full_contiguous: got %0d expected %0d", st[4] - st[0], 40*CPB); end
    wait_idle(to);
  endtask

  task automatic test_push_pop();
    logic [7:0] got [4];
    bit ok [4];
    bit tov [4];
    int st [4];
    bit to;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          TX_valid = 1'b1; TX_data = 8'h81 + 8'(i);
          @(negedge Clk);
        end
        TX_valid = 1'b0;
        repeat (238) @(negedge Clk);
        n_checks++; if (Fifo_count !== 3'd2 || TX !== 1'b1) begin n_fail++; $display("FAIL pp_before: got count=%0d tx=%b expected count=2 tx=1", Fifo_count, TX); end
        TX_valid = 1'b1; TX_data = 8'h84;
        @(negedge Clk);
        TX_valid = 1'b0;
        n_checks++; if (Fifo_count !== 3'd2 || TX !== 1'b0) begin n_fail++; $display("FAIL pp_after: got count=%0d tx=%b expected count=2 tx=0", Fifo_count, TX); end
      end
      begin
        for (int i = 0; i < 4; i++) rx_byte(got[i], ok[i], tov[i], st[i]);
      end
    join
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tov[i] || !ok[i] || got[i] !== 8'h81 + 8'(i)) begin n_fail++; $display("FAIL pp_byte%0d: got %h ok=%b to=%b expected %h ok=1 to=0", i, got[i], ok[i], tov[i], 8'h81 + 8'(i)); end
    end
    wait_idle(to);
  endtask

  task automatic test_reset_mid();
    int bad;
    TX_valid = 1'b1; TX_data = 8'hF0;
    @(negedge Clk);
    TX_data = 8'h77;
    @(negedge Clk);
    TX_valid = 1'b0;
    repeat (99) @(negedge Clk);
    n_checks++; if (TX !== 1'b0 || Fifo_count !== 3'd1) begin n_fail++; $display("FAIL rst_bit3: got tx=%b count=%0d expected tx=0 count=1", TX, Fifo_count); end
    Reset = 1'b0; TX_valid = 1'b1; TX_data = 8'hEE;
    @(negedge Clk);
    n_checks++; if (TX !== 1'b1 || Fifo_count !== 3'd0 || TX_ready !== 1'b1 || TX_busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got tx=%b count=%0d ready=%b busy=%b expected 1 0 1 0", TX, Fifo_count, TX_ready, TX_busy); end
    @(negedge Clk);
    TX_valid = 1'b0; Reset = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge Clk);
      if (TX !== 1'b1 || TX_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_residual: got %0d active samples expected 0", bad); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [3];
    logic [7:0] got [3];
    bit ok [3];
    bit tov [3];
    int st [3];
    bit to;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          TX_valid = 1'b1; TX_data = exp_b[i];
          @(negedge Clk);
        end
        TX_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) rx_byte(got[i], ok[i], tov[i], st[i]);
      end
    join
    n_checks++; if (tov[0] || !ok[0] || got[0] !== 8'h00) begin n_fail++; $display("FAIL loop_00: got %h ok=%b to=%b expected 00 ok=1 to=0", got[0], ok[0], tov[0]); end
    n_checks++; if (tov[1] || !ok[1] || got[1] !== 8'hFF) begin n_fail++; $display("FAIL loop_ff: got %h ok=%b to=%b expected ff ok=1 to=0", got[1], ok[1], tov[1]); end
    n_checks++; if (tov[2] || !ok[2] || got[2] !== 8'h3C) begin n_fail++; $display("FAIL loop_3c: got %h ok=%b to=%b expected 3c ok=1 to=0", got[2], ok[2], tov[2]); end
    wait_idle(to);
    n_checks++; if (to || TX !== 1'b1) begin n_fail++; $display("FAIL loop_idle: got busy=%b tx=%b expected busy=0 tx=1", TX_busy, TX); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 24, meaning clock cycles per serial bit (start, data and stop bits alike).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning number of byte entries in the transmit buffer (power of two).
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-005 TX_data  input  8  byte to transmit, qualified by TX_valid.
REQ-006 TX_valid  input  1  byte offered this cycle.
REQ-007 TX_ready  output  1  buffer can accept a byte this cycle.
REQ-008 TX  output  1  serial line: idle high, 8N1 framing, LSB first; driven from a register.
REQ-009 TX_busy  output  1  high while a frame is on the line or the buffer is non-empty.
REQ-010 Fifo_count  output  3  number of bytes buffered, excluding the byte in the shifter.

Function
REQ-011 A byte SHALL be accepted on a rising edge where TX_valid=1 and TX_ready=1; there is no other accept condition.
REQ-012 TX_ready SHALL be 1 exactly when Fifo_count<FIFO_DEPTH; a push on a full buffer SHALL be ignored even if a pop occurs on the same edge.
REQ-013 A simultaneous push and pop SHALL leave Fifo_count unchanged and preserve FIFO order.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: TX=1; on an edge where the buffer is non-empty, pop the head into the shifter, clear the baud counter, and go to START.
REQ-016 START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: TX=shifter[index] for CLKS_PER_BIT cycles per bit; index counts 0..7; after bit 7 go to STOP.
REQ-018 STOP: TX=1 for CLKS_PER_BIT cycles; at the end, if the buffer is non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-019 Latency: a byte accepted at edge N into an empty buffer while in IDLE SHALL drive TX=0 from edge N+1.
REQ-020 One frame SHALL last exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-022 A shifter byte SHALL NOT change mid-frame; new pushes affect only the buffer.
REQ-023 TX_busy SHALL be 0 only in IDLE with Fifo_count=0.

Reset
REQ-024 While Reset=0 on an edge: state=IDLE, TX=1, TX_busy=0, Fifo_count=0, TX_ready=1, counters cleared, and buffer contents discarded.
REQ-025 Reset asserted mid-frame SHALL abort the frame: TX=1 from the next edge, with no partial stop bit or further bits.
REQ-026 Inputs SHALL be ignored during reset; operation resumes on the first edge with Reset=1.

Structure
REQ-027 Shared package uart_pkg SHALL hold the CLKS_PER_BIT default, the frame constants (DATA_BITS=8, STOP_BITS=1) and the FSM state encoding, so the existing receiver uses the same values.
REQ-028 The buffer SHALL be a sub-module uart_fifo (synchronous FIFO with push, pop, full, empty and count); the FSM, baud counter and shifter stay in uart_tx.

Verification
REQ-029 Single byte: push 0xA5 in idle -> TX=0,1,0,1,0,0,1,0,1,1, each bit 24 cycles, start bit at edge N+1, TX_busy falls after 240 cycles.
REQ-030 Back-to-back: push 0x55 then 0x0F on consecutive cycles -> 480 contiguous cycles with no idle cycle between the stop bit of 0x55 and the start bit of 0x0F.
REQ-031 Full buffer: hold TX_valid=1 for 10 cycles from idle -> exactly 5 bytes accepted (1 in shifter, 4 buffered), TX_ready=0 with Fifo_count=4, and all 5 bytes appear in order on TX.
REQ-032 Simultaneous push and pop: push at the end-of-stop edge while Fifo_count=2 -> Fifo_count stays 2 and byte order is preserved.
REQ-033 Reset mid-frame: Reset=0 during bit 3 of 0xF0 -> TX=1, Fifo_count=0, TX_ready=1 from the next edge; no residual frame after release.
REQ-034 Loopback: drive TX into a bench UART receiver at 24 cycles per bit, send 0x00, 0xFF, 0x3C -> the receiver decodes identical bytes with valid stop bits.
